// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter loading one of four 4-bit requester lanes into a shared
// register, one load slot per prescaler wrap (every 2^DIV_W clocks).
module reg_load_arbiter #(
    parameter int unsigned DIV_W = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] din,
    input  logic        clr,
    output logic [3:0]  dout,
    output logic [3:0]  gnt,
    output logic [1:0]  owner,
    output logic        dvalid,
    output logic        tick
);

    typedef enum logic {
        ST_WAIT  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_presc;
    logic [3:0]       r_dout;
    logic [3:0]       r_gnt;
    logic [1:0]       r_owner;
    logic [1:0]       r_ptr;
    logic             r_dvalid;

    logic [3:0]       w_dout_nxt;
    logic [3:0]       w_gnt_nxt;
    logic [1:0]       w_owner_nxt;
    logic [1:0]       w_ptr_nxt;
    logic             w_dvalid_nxt;
    logic             w_tick;
    logic             w_hit;
    logic [1:0]       w_sel;
    logic [1:0]       w_idx;

    assign w_tick = &r_presc;
    assign tick   = w_tick;
    assign dout   = r_dout;
    assign gnt    = r_gnt;
    assign owner  = r_owner;
    assign dvalid = r_dvalid;

    // Round-robin search starting just after the last winner; ptr itself is tried last.
    always_comb begin
        w_sel = r_ptr;
        w_hit = 1'b0;
        w_idx = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_hit && req[w_idx]) begin
                w_hit = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    // Next-state and next-output logic; clr always beats a load slot.
    always_comb begin
        w_state_nxt  = r_state;
        w_dout_nxt   = r_dout;
        w_gnt_nxt    = 4'b0000;
        w_owner_nxt  = r_owner;
        w_ptr_nxt    = r_ptr;
        w_dvalid_nxt = r_dvalid;
        case (r_state)
            ST_WAIT: begin
                if (clr) begin
                    w_dout_nxt   = 4'h0;
                    w_dvalid_nxt = 1'b0;
                end else if (w_tick && w_hit) begin
                    w_state_nxt  = ST_GRANT;
                    w_dout_nxt   = din[4*w_sel +: 4];
                    w_gnt_nxt    = 4'b0001 << w_sel;
                    w_owner_nxt  = w_sel;
                    w_ptr_nxt    = w_sel;
                    w_dvalid_nxt = 1'b1;
                end
            end
            ST_GRANT: begin
                w_state_nxt = ST_WAIT;
                if (clr) begin
                    w_dout_nxt   = 4'h0;
                    w_dvalid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers; ptr resets to 3 so requester 0 wins the first slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc  <= '0;
            r_dout   <= 4'h0;
            r_gnt    <= 4'b0000;
            r_owner  <= 2'd0;
            r_ptr    <= 2'd3;
            r_dvalid <= 1'b0;
        end else begin
            r_presc  <= r_presc + DIV_W'(1);
            r_dout   <= w_dout_nxt;
            r_gnt    <= w_gnt_nxt;
            r_owner  <= w_owner_nxt;
            r_ptr    <= w_ptr_nxt;
            r_dvalid <= w_dvalid_nxt;
        end
    end

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Self-checking bench for reg_load_arbiter at DIV_W=2: directed table, hand
// sequences for multi-cycle corners, and random traffic against a slot model.
module tb_reg_load_arbiter;

    localparam int unsigned DIV_W = 2;
    localparam int unsigned SLOT  = 1 << DIV_W;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] din;
    logic        clr;
    logic [3:0]  dout;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        dvalid;
    logic        tick;

    int checks;
    int failures;
    int cyc;
    bit chk_model;

    // reference state: what the register file should hold after each edge
    logic [3:0] m_dout;
    logic [3:0] m_gnt;
    logic [1:0] m_owner;
    logic       m_dv;
    int         m_ptr;

    typedef struct packed {
        logic [3:0]  req;
        logic [15:0] din;
        logic        clr;
        logic [3:0]  gnt;
        logic [3:0]  dout;
        logic [1:0]  owner;
        logic        dv;
        logic        tick;
    } vec_t;

    vec_t vecs [8];

    reg_load_arbiter #(.DIV_W(DIV_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .din    (din),
        .clr    (clr),
        .dout   (dout),
        .gnt    (gnt),
        .owner  (owner),
        .dvalid (dvalid),
        .tick   (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_dout  = 4'h0;
        m_gnt   = 4'b0000;
        m_owner = 2'd0;
        m_dv    = 1'b0;
        m_ptr   = 3;
        cyc     = 0;
    endtask

    // One clock edge of the spec's rules, using the inputs held across the edge.
    task automatic model_edge();
        bit slot;
        int idx;
        slot = ((cyc % SLOT) == (SLOT - 1));
        if (m_gnt != 4'b0000) begin
            m_gnt = 4'b0000;
            if (clr) begin
                m_dout = 4'h0;
                m_dv   = 1'b0;
            end
        end else if (clr) begin
            m_dout = 4'h0;
            m_dv   = 1'b0;
        end else if (slot && req != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (req[idx]) break;
            end
            m_gnt   = 4'(1 << idx);
            m_dout  = din[idx*4 +: 4];
            m_owner = 2'(idx);
            m_ptr   = idx;
            m_dv    = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        if (chk_model) begin
            chk("rnd_gnt",    16'(gnt),    16'(m_gnt));
            chk("rnd_dout",   16'(dout),   16'(m_dout));
            chk("rnd_owner",  16'(owner),  16'(m_owner));
            chk("rnd_dvalid", 16'(dvalid), 16'(m_dv));
            chk("rnd_tick",   16'(tick),   16'((cyc % SLOT) == (SLOT - 1)));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b0000;
        din   = 16'h0000;
        clr   = 1'b0;
        @(negedge clk);
        chk("rst_gnt",    16'(gnt),    16'h0);
        chk("rst_dout",   16'(dout),   16'h0);
        chk("rst_owner",  16'(owner),  16'h0);
        chk("rst_dvalid", 16'(dvalid), 16'h0);
        chk("rst_tick",   16'(tick),   16'h0);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic chk_out(input string nm, input logic [3:0] eg, input logic [3:0] ed,
                           input logic [1:0] eo, input logic ev);
        chk({nm, "_gnt"},    16'(gnt),    16'(eg));
        chk({nm, "_dout"},   16'(dout),   16'(ed));
        chk({nm, "_owner"},  16'(owner),  16'(eo));
        chk({nm, "_dvalid"}, 16'(dvalid), 16'(ev));
    endtask

    logic [3:0] exp_g [5];
    logic [3:0] exp_d [5];

    initial begin
        checks    = 0;
        failures  = 0;
        chk_model = 1'b0;
        reset     = 1'b0;
        req       = 4'b0000;
        din       = 16'h0000;
        clr       = 1'b0;
        model_reset();

        // first-slot load, then hold with no requests across a later slot
        vecs[0] = '{4'b0001, 16'h000A, 1'b0, 4'b0000, 4'h0, 2'd0, 1'b0, 1'b0};
        vecs[1] = '{4'b0001, 16'h000A, 1'b0, 4'b0000, 4'h0, 2'd0, 1'b0, 1'b0};
        vecs[2] = '{4'b0001, 16'h000A, 1'b0, 4'b0000, 4'h0, 2'd0, 1'b0, 1'b1};
        vecs[3] = '{4'b0001, 16'h000A, 1'b0, 4'b0001, 4'hA, 2'd0, 1'b1, 1'b0};
        vecs[4] = '{4'b0000, 16'h000A, 1'b0, 4'b0000, 4'hA, 2'd0, 1'b1, 1'b0};
        vecs[5] = '{4'b0000, 16'hFFFF, 1'b0, 4'b0000, 4'hA, 2'd0, 1'b1, 1'b0};
        vecs[6] = '{4'b0000, 16'hFFFF, 1'b0, 4'b0000, 4'hA, 2'd0, 1'b1, 1'b1};
        vecs[7] = '{4'b0000, 16'hFFFF, 1'b0, 4'b0000, 4'hA, 2'd0, 1'b1, 1'b0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req;
            din = vecs[i].din;
            clr = vecs[i].clr;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].dout, vecs[i].owner, vecs[i].dv);
            chk($sformatf("vec%0d_tick", i), 16'(tick), 16'(vecs[i].tick));
        end

        // four persistent requesters served 0,1,2,3,0
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
        do_reset();
        req = 4'b1111;
        din = 16'h4321;
        for (int g = 0; g < 5; g++) begin
            for (int s = 0; s < 4; s++) begin
                step();
                if (s == 3) begin
                    chk($sformatf("rr%0d_gnt", g),  16'(gnt),  16'(exp_g[g]));
                    chk($sformatf("rr%0d_dout", g), 16'(dout), 16'(exp_d[g]));
                end else begin
                    chk($sformatf("rr%0d_idle_gnt", g), 16'(gnt), 16'h0);
                end
            end
        end

        // ptr=0 with req 1001: 3 wins, then 0
        req = 4'b1001;
        repeat (4) step();
        chk_out("wrap3", 4'b1000, 4'h4, 2'd3, 1'b1);
        repeat (4) step();
        chk_out("wrap0", 4'b0001, 4'h1, 2'd0, 1'b1);

        // clr in the slot cycle wins over a pending request
        req = 4'b0010;
        repeat (3) step();
        clr = 1'b1;
        step();
        chk_out("clrtick", 4'b0000, 4'h0, 2'd0, 1'b0);
        clr = 1'b0;
        repeat (4) step();
        chk_out("afterclr", 4'b0010, 4'h2, 2'd1, 1'b1);

        // asynchronous reset inside the grant cycle
        #2;
        reset = 1'b0;
        #1;
        chk_out("rstgrant", 4'b0000, 4'h0, 2'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        req = 4'b1111;
        din = 16'h4321;
        repeat (4) step();
        chk_out("ptr3", 4'b0001, 4'h1, 2'd0, 1'b1);

        // short request pulse that ends before the slot
        req = 4'b0000;
        step();
        chk_out("pulse_a", 4'b0000, 4'h1, 2'd0, 1'b1);
        req = 4'b0100;
        din = 16'hEEEE;
        step();
        chk_out("pulse_b", 4'b0000, 4'h1, 2'd0, 1'b1);
        step();
        chk_out("pulse_c", 4'b0000, 4'h1, 2'd0, 1'b1);
        req = 4'b0000;
        step();
        chk_out("pulse_d", 4'b0000, 4'h1, 2'd0, 1'b1);

        // random traffic against the model
        do_reset();
        chk_model = 1'b1;
        for (int i = 0; i < 400; i++) begin
            req = 4'($urandom);
            din = 16'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            step();
        end
        chk_model = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
